sysctl_icap_rd: RTL and testbench

//  Reads back one 16-bit Spartan-6 configuration register through the ICAP port. It is the

---
 rtl/sysctl_icap_rd.sv | 139 +++++++++++++
 tb/tb_sysctl_icap_rd.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sysctl_icap_rd.sv
// sysctl_icap_rd: reads one 16-bit Spartan-6 config register over raw ICAP pins
// (sync, type-1 read header, BUSY-polled read, desync); six sys_clk phases per ICAP cycle.
module sysctl_icap_rd #(
    parameter int TIMEOUT = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [5:0]  addr,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [15:0] dout,
    output logic        icap_clk,
    output logic        icap_ce,
    output logic        icap_write,
    output logic [15:0] icap_i,
    input  logic [15:0] icap_o,
    input  logic        icap_busy
);
    localparam int RW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] RLAST = RW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, HDR, SW_RD, READ, SW_WR, DESYNC, FIN} state_t;

    state_t        st, nxt;
    logic [2:0]    ph, idx, nxt_idx;
    logic [RW-1:0] rcnt;
    logic [5:0]    addr_l;
    logic          busy_q, seq, step, ce_n, wr_n;
    logic [15:0]   data_q, word_n;

    function automatic logic [15:0] swap(input logic [15:0] w);
        logic [15:0] r;
        for (int k = 0; k < 8; k++) begin
            r[7-k]  = w[k];
            r[15-k] = w[8+k];
        end
        return r;
    endfunction

    // Sequence states advance only at the end of P5; IDLE/FIN react every cycle.
    assign seq  = st != IDLE && st != FIN;
    assign step = !seq || ph == 3'd5;

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            st  <= IDLE;
            idx <= 3'd0;
        end else if (step) begin
            st  <= nxt;
            idx <= nxt_idx;
        end

    always_comb begin
        nxt     = st;
        nxt_idx = idx;
        case (st)
            IDLE, FIN: begin
                nxt     = start ? HDR : IDLE;
                nxt_idx = 3'd0;
            end
            HDR: begin
                nxt     = idx == 3'd6 ? SW_RD : HDR;
                nxt_idx = idx == 3'd6 ? 3'd0 : idx + 3'd1;
            end
            SW_RD:   nxt = READ;
            READ:    nxt = (!busy_q || rcnt == RLAST) ? SW_WR : READ;
            SW_WR: begin
                nxt     = idx == 3'd1 ? DESYNC : SW_WR;
                nxt_idx = idx == 3'd1 ? 3'd0 : idx + 3'd1;
            end
            DESYNC: begin
                nxt     = idx == 3'd3 ? FIN : DESYNC;
                nxt_idx = idx == 3'd3 ? 3'd0 : idx + 3'd1;
            end
            default: nxt = IDLE;
        endcase
    end

    // Pin values are derived from the state being entered, so they load on the P0 edge.
    always_comb begin
        ready  = !seq;
        done   = st == FIN;
        ce_n   = !(nxt == HDR || nxt == READ || nxt == DESYNC);
        wr_n   = nxt == SW_RD || nxt == READ || (nxt == SW_WR && nxt_idx == 3'd0);
        word_n = 16'h0000;
        if (nxt == HDR)
            case (nxt_idx)
                3'd0:    word_n = 16'hFFFF;
                3'd1:    word_n = 16'hAA99;
                3'd2:    word_n = 16'h5566;
                3'd4:    word_n = 16'h2801 | {5'd0, addr_l, 5'd0};
                default: word_n = 16'h2000;
            endcase
        else if (nxt == DESYNC)
            case (nxt_idx)
                3'd0:    word_n = 16'h30A1;
                3'd1:    word_n = 16'h000D;
                default: word_n = 16'h2000;
            endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            ph         <= 3'd0;
            rcnt       <= '0;
            addr_l     <= 6'd0;
            busy_q     <= 1'b0;
            data_q     <= 16'h0000;
            dout       <= 16'h0000;
            err        <= 1'b0;
            icap_clk   <= 1'b0;
            icap_ce    <= 1'b1;
            icap_write <= 1'b0;
            icap_i     <= 16'h0000;
        end else begin
            ph       <= (seq && ph != 3'd5) ? ph + 3'd1 : 3'd0;
            icap_clk <= seq && ph >= 3'd1 && ph <= 3'd3;
            if (ph == 3'd4) begin
                busy_q <= icap_busy;
                data_q <= icap_o;
            end
            if (!seq && start) addr_l <= addr;
            if (step) begin
                icap_ce    <= ce_n;
                icap_write <= wr_n;
                icap_i     <= swap(word_n);
            end
            if (step && st == SW_RD) rcnt <= '0;
            if (step && st == READ) begin
                rcnt <= rcnt + 1'b1;
                if (!busy_q) begin
                    dout <= swap(data_q);
                    err  <= 1'b0;
                end else if (rcnt == RLAST) err <= 1'b1;
            end
        end
endmodule

// File: tb/tb_sysctl_icap_rd.sv
// tb_sysctl_icap_rd: randomized readbacks against a transaction-level ICAP model;
// expected pin sequence, latency, dout and err are derived from the read protocol.
module tb_sysctl_icap_rd;
    logic        clk = 0, rst_n = 0, start = 0;
    logic [5:0]  addr = 0;
    logic        ready, done, err, icap_clk, icap_ce, icap_write;
    logic [15:0] dout, icap_i;
    logic [15:0] icap_o = 0;
    logic        icap_busy = 1;

    int n_chk = 0, n_pass = 0, cyc = 0;
    int nb = 0, rd = 0, hw = 0;
    logic [15:0] dat = 0, exp_dout = 0;
    logic        exp_err = 0, prev = 0;
    logic [17:0] cyc_q[$];

    sysctl_icap_rd #(.TIMEOUT(16)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .addr(addr),
        .ready(ready), .done(done), .err(err), .dout(dout),
        .icap_clk(icap_clk), .icap_ce(icap_ce), .icap_write(icap_write),
        .icap_i(icap_i), .icap_o(icap_o), .icap_busy(icap_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] swp(input logic [15:0] w);
        logic [15:0] r = 0;
        for (int i = 0; i < 16; i++) r[(i & 8) | (7 - (i & 7))] = w[i];
        return r;
    endfunction

    // ICAP device model: records each ICAP cycle at its rising clock, answers read cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev = 0;
            hw   = 0;
        end else begin
            if (icap_clk && !prev) begin
                cyc_q.push_back({icap_ce, icap_write, swp(icap_i)});
                if (!icap_ce && icap_write) begin
                    rd++;
                    icap_busy = rd <= nb;
                    icap_o    = swp(dat);
                end else begin
                    icap_busy = 1;
                    icap_o    = 16'($urandom);
                end
            end
            if (icap_clk) hw++;
            else if (hw != 0) begin
                check("icap_clk_width", hw, 3);
                hw = 0;
            end
            prev = icap_clk;
        end
    end

    task automatic check_reset(input string tag);
        check(tag, {ready, done, err, dout, icap_clk, icap_ce, icap_write, icap_i},
              {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0});
    endtask

    // Caller is at a negedge; returns at the negedge where done was seen (or after it).
    task automatic run(input logic [5:0] a, input int nbusy, input logic [15:0] d,
                       input bit hold, input bit glitch);
        int t0, n;
        logic [17:0] exp_q[$];
        logic [17:0] g;
        logic [15:0] hdr[7] = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h2000, 16'h0, 16'h2000, 16'h2000};
        logic [15:0] dsy[4] = '{16'h30A1, 16'h000D, 16'h2000, 16'h2000};
        nb = nbusy;
        dat = d;
        rd = 0;
        cyc_q.delete();
        addr = a;
        start = 1;
        @(negedge clk);
        t0 = cyc;
        start = hold;
        check("ready_busy", ready, 0);
        while (!done && cyc - t0 < 400) begin
            addr  = 6'($urandom);
            start = hold || (glitch && (cyc - t0 == 10 || cyc - t0 == 52));
            @(negedge clk);
        end
        n = nbusy < 16 ? nbusy + 1 : 16;
        if (nbusy < 16) begin
            exp_dout = d;
            exp_err  = 0;
        end else exp_err = 1;
        check("done_seen", done, 1);
        check("latency", cyc - t0, 6 * (14 + n));
        check("ready_at_done", ready, 1);
        check("dout", dout, exp_dout);
        check("err", err, exp_err);
        hdr[4] = 16'h2801 | ({10'd0, a} << 5);
        foreach (hdr[k]) exp_q.push_back({2'b00, hdr[k]});
        exp_q.push_back({2'b11, 16'h0});
        repeat (n) exp_q.push_back({2'b01, 16'h0});
        exp_q.push_back({2'b11, 16'h0});
        exp_q.push_back({2'b10, 16'h0});
        foreach (dsy[k]) exp_q.push_back({2'b00, dsy[k]});
        check("icap_cycles", cyc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cyc_q.size(); i++) begin
            g = cyc_q[i];
            if (g[17:16] != 2'b00) g[15:0] = 16'h0;
            check($sformatf("icap_cyc%0d", i), g, exp_q[i]);
        end
        if (!hold) begin
            start = 0;
            @(negedge clk);
            check("done_pulse", done, 0);
            check("idle_ready", ready, 1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset("reset_state");
        rst_n = 1;
        @(negedge clk);
        run(6'h0C, 0, 16'h4000, 0, 0);
        run(6'($urandom), 3, 16'h1234, 0, 0);
        run(6'($urandom), 1000, 16'hBEEF, 0, 0);
        run(6'($urandom), 15, 16'h5A5A, 0, 0);
        // asynchronous reset in the middle of header word 3
        addr = 6'h15;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (19) @(negedge clk);
        rst_n = 0;
        #1 check_reset("reset_async");
        exp_dout = 0;
        @(negedge clk);
        check_reset("reset_held");
        rst_n = 1;
        @(negedge clk);
        check_reset("reset_release");
        run(6'h2A, 2, 16'hC3A5, 0, 1);
        run(6'($urandom), 0, 16'h0F0F, 1, 0);
        run(6'($urandom), 4, 16'h8001, 0, 0);
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(6'($urandom), int'($urandom_range(0, 20)), 16'($urandom), 0, 1'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
